pe_dmem_dma: RTL and testbench

Block-transfer sequencer for port A (bus side) of the PE data memory. It accepts one host command at a time: a byte base address, a word count and a direction. It then moves that many 32-bit words between a valid/ready stream and the memory, generating consecutive word addresses. It sits between the host/bus interconnect and the DMEM bus port. It is the only master of that port while the array is loaded or drained.

---
 rtl/pe_dmem_dma.sv | 165 ++++++++++++++++
 tb/tb_pe_dmem_dma.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dmem_dma.sv
// Block-transfer sequencer for DMEM port A: moves a counted run of words between a
// valid/ready stream and consecutive memory addresses, one command at a time.
module pe_dmem_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iCmd_Valid,
  output logic                  oCmd_Ready,
  input  logic                  iCmd_Write,
  input  logic [ADDR_WIDTH-1:0] iCmd_Address,
  input  logic [LEN_WIDTH-1:0]  iCmd_Length,
  input  logic                  iWr_Valid,
  output logic                  oWr_Ready,
  input  logic [DATA_WIDTH-1:0] iWr_Data,
  output logic                  oRd_Valid,
  input  logic                  iRd_Ready,
  output logic [DATA_WIDTH-1:0] oRd_Data,
  output logic                  oBus_Valid,
  output logic                  oBus_Write_Enable,
  output logic [ADDR_WIDTH-1:0] oBus_Address,
  output logic [DATA_WIDTH-1:0] oBus_Write_Data,
  input  logic [DATA_WIDTH-1:0] iBus_Read_Data,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam int RD_DEPTH = 3;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [RD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [RD_DEPTH];

  logic cmd_rdy, wr_rdy, bus_vld, bus_we, done, rd_vld, pop, issue;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    issue_cnt_d = issue_cnt_q;
    inflight_d  = 1'b0;
    occ_d       = occ_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_d      = fifo_q;
    cmd_rdy     = 1'b0;
    wr_rdy      = 1'b0;
    bus_vld     = 1'b0;
    bus_we      = 1'b0;
    done        = 1'b0;
    issue       = 1'b0;
    rd_vld      = (occ_q != 2'd0);
    pop         = rd_vld & iRd_Ready;

    // Read data returns one cycle after its request; the issue rule keeps room for it.
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = iBus_Read_Data;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        cmd_rdy = ~iReset;
        if (iCmd_Valid && cmd_rdy) begin
          addr_d      = iCmd_Address & ~ADDR_WIDTH'(3);
          rem_d       = iCmd_Length;
          issue_cnt_d = iCmd_Length;
          if (iCmd_Length == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = iCmd_Write ? S_WRITE : S_READ;
          end
        end
      end
      S_WRITE: begin
        wr_rdy = 1'b1;
        if (iWr_Valid) begin
          bus_vld = 1'b1;
          bus_we  = 1'b1;
          addr_d  = addr_q + ADDR_WIDTH'(4);
          rem_d   = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        issue = (issue_cnt_q != '0) &&
                (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
        if (issue) begin
          bus_vld     = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(4);
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
          inflight_d  = 1'b1;
        end
        if (pop) begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      fifo_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_q      <= fifo_d;
    end
  end

  assign oCmd_Ready        = cmd_rdy;
  assign oWr_Ready         = wr_rdy;
  assign oRd_Valid         = rd_vld;
  assign oRd_Data          = fifo_q[rd_ptr_q];
  assign oBus_Valid        = bus_vld;
  assign oBus_Write_Enable = bus_we;
  assign oBus_Address      = addr_q;
  assign oBus_Write_Data   = iWr_Data;
  assign oBusy             = (state_q != S_IDLE);
  assign oDone             = done;

endmodule

// File: tb/tb_pe_dmem_dma.sv
// Directed bench for pe_dmem_dma with a registered-read DMEM model and stream monitors.
module tb_pe_dmem_dma;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iCmd_Valid, oCmd_Ready, iCmd_Write;
  logic [11:0] iCmd_Address;
  logic [8:0]  iCmd_Length;
  logic        iWr_Valid, oWr_Ready;
  logic [31:0] iWr_Data;
  logic        oRd_Valid, iRd_Ready;
  logic [31:0] oRd_Data;
  logic        oBus_Valid, oBus_Write_Enable;
  logic [11:0] oBus_Address;
  logic [31:0] oBus_Write_Data, iBus_Read_Data;
  logic        oBusy, oDone;

  int checks = 0;
  int errors = 0;

  // monitor state
  int          acc_cnt = 0, bus_cnt = 0, pop_cnt = 0, done_cnt = 0;
  int          outst = 0, max_out = 0, pops_at_done = 0;
  logic [31:0] rd_q [$];
  logic [31:0] dmem [0:1023];

  int   rb, pb, db, ab, bb;
  logic done_seen;

  always #5 iClk = ~iClk;

  pe_dmem_dma dut (
    .iClk(iClk), .iReset(iReset),
    .iCmd_Valid(iCmd_Valid), .oCmd_Ready(oCmd_Ready), .iCmd_Write(iCmd_Write),
    .iCmd_Address(iCmd_Address), .iCmd_Length(iCmd_Length),
    .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready), .iWr_Data(iWr_Data),
    .oRd_Valid(oRd_Valid), .iRd_Ready(iRd_Ready), .oRd_Data(oRd_Data),
    .oBus_Valid(oBus_Valid), .oBus_Write_Enable(oBus_Write_Enable),
    .oBus_Address(oBus_Address), .oBus_Write_Data(oBus_Write_Data),
    .iBus_Read_Data(iBus_Read_Data), .oBusy(oBusy), .oDone(oDone)
  );

  always @(posedge iClk) begin
    if (oBus_Valid && oBus_Write_Enable) dmem[oBus_Address[11:2]] <= oBus_Write_Data;
    if (oBus_Valid && !oBus_Write_Enable) iBus_Read_Data <= dmem[oBus_Address[11:2]];
  end

  always @(negedge iClk) begin
    if (iCmd_Valid && oCmd_Ready) acc_cnt++;
    if (oBus_Valid) bus_cnt++;
    if (oBus_Valid && !oBus_Write_Enable) outst++;
    if (oRd_Valid && iRd_Ready) begin
      outst--;
      rd_q.push_back(oRd_Data);
      pop_cnt++;
    end
    if (outst > max_out) max_out = outst;
    if (oDone) begin
      done_cnt++;
      pops_at_done = pop_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [11:0] a, input logic [8:0] len,
                          input logic hold);
    logic ok;
    ok = 1'b0;
    iCmd_Valid = 1'b1; iCmd_Write = w; iCmd_Address = a; iCmd_Length = len;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge iClk);
      ok = oCmd_Ready;
      tick();
    end
    if (!hold) iCmd_Valid = 1'b0;
    chk("cmd_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_write(input logic [11:0] a, input int len, input logic [31:0] d0);
    logic [11:0] ea;
    send_cmd(1'b1, a, 9'(len), 1'b0);
    ea = a & 12'hFFC;
    for (int i = 0; i < len; i++) begin
      iWr_Valid = 1'b1;
      iWr_Data  = d0 + 32'(i);
      @(negedge iClk);
      chk("wr_rdy", {31'd0, oWr_Ready}, 32'd1);
      chk("wr_bus_vld", {31'd0, oBus_Valid}, 32'd1);
      chk("wr_bus_we", {31'd0, oBus_Write_Enable}, 32'd1);
      chk("wr_bus_addr", {20'd0, oBus_Address}, {20'd0, ea});
      chk("wr_bus_dat", oBus_Write_Data, d0 + 32'(i));
      ea = ea + 12'd4;
      tick();
    end
    iWr_Valid = 1'b0;
    iWr_Data  = 32'd0;
    @(negedge iClk);
    chk("wr_done", {31'd0, oDone}, 32'd1);
    chk("wr_done_bus_idle", {31'd0, oBus_Valid}, 32'd0);
    tick();
    @(negedge iClk);
    chk("wr_idle_rdy", {31'd0, oCmd_Ready}, 32'd1);
    chk("wr_idle_done", {31'd0, oDone}, 32'd0);
    tick();
  endtask

  task automatic do_read(input logic [11:0] a, input int len, input logic [31:0] d0);
    logic [11:0] ea;
    int p0, d_0;
    p0  = pop_cnt;
    d_0 = done_cnt;
    iRd_Ready = 1'b1;
    send_cmd(1'b0, a, 9'(len), 1'b0);
    ea = a & 12'hFFC;
    for (int k = 1; k <= len + 3; k++) begin
      @(negedge iClk);
      if (k <= len) begin
        chk("rd_bus_vld", {31'd0, oBus_Valid}, 32'd1);
        chk("rd_bus_we", {31'd0, oBus_Write_Enable}, 32'd0);
        chk("rd_bus_addr", {20'd0, oBus_Address}, {20'd0, ea});
        ea = ea + 12'd4;
      end
      if (k < 3) begin
        chk("rd_vld_early", {31'd0, oRd_Valid}, 32'd0);
      end else if (k <= len + 2) begin
        chk("rd_vld", {31'd0, oRd_Valid}, 32'd1);
        chk("rd_dat", oRd_Data, d0 + 32'(k - 3));
      end else begin
        chk("rd_done", {31'd0, oDone}, 32'd1);
      end
      tick();
    end
    iRd_Ready = 1'b0;
    chk("rd_pops", 32'(pop_cnt - p0), 32'(len));
    chk("rd_done_cnt", 32'(done_cnt - d_0), 32'd1);
  endtask

  initial begin
    iReset = 1'b1; iCmd_Valid = 1'b0; iCmd_Write = 1'b0; iCmd_Address = '0;
    iCmd_Length = '0; iWr_Valid = 1'b0; iWr_Data = '0; iRd_Ready = 1'b0;

    // reset state
    tick();
    @(negedge iClk);
    chk("rst_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_done", {31'd0, oDone}, 32'd0);
    chk("rst_bus_vld", {31'd0, oBus_Valid}, 32'd0);
    chk("rst_rd_vld", {31'd0, oRd_Valid}, 32'd0);
    chk("rst_cmd_rdy", {31'd0, oCmd_Ready}, 32'd0);
    chk("rst_wr_rdy", {31'd0, oWr_Ready}, 32'd0);
    chk("rst_bus_addr", {20'd0, oBus_Address}, 32'd0);
    tick();
    iReset = 1'b0;
    @(negedge iClk);
    chk("post_rst_cmd_rdy", {31'd0, oCmd_Ready}, 32'd1);
    chk("post_rst_busy", {31'd0, oBusy}, 32'd0);
    tick();

    // 4-word write at unaligned 0x013, then read back from 0x010
    do_write(12'h013, 4, 32'hA0);
    chk("mem_010", dmem[4], 32'hA0);
    chk("mem_01c", dmem[7], 32'hA3);
    do_read(12'h010, 4, 32'hA0);

    // 8-word read under backpressure
    do_write(12'h200, 8, 32'hB0);
    rb = rd_q.size();
    pb = pop_cnt;
    db = done_cnt;
    done_seen = 1'b0;
    send_cmd(1'b0, 12'h200, 9'd8, 1'b0);
    for (int c = 1; c <= 300 && !done_seen; c++) begin
      iRd_Ready = (c >= 3 && c < 13) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge iClk);
      if (c == 12) begin
        chk("bp_full_vld", {31'd0, oRd_Valid}, 32'd1);
        chk("bp_stall", {31'd0, oBus_Valid}, 32'd0);
      end
      if (oDone) done_seen = 1'b1;
      tick();
    end
    iRd_Ready = 1'b0;
    chk("bp_done_seen", {31'd0, done_seen}, 32'd1);
    chk("bp_pops", 32'(pop_cnt - pb), 32'd8);
    chk("bp_pops_at_done", 32'(pops_at_done - pb), 32'd8);
    chk("bp_done_cnt", 32'(done_cnt - db), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("bp_dat", (rb + i < rd_q.size()) ? rd_q[rb + i] : 32'hDEAD_BEEF, 32'hB0 + 32'(i));
    end
    chk("bp_max_outstanding", 32'(max_out), 32'd3);

    // address wrap at the top of the space
    do_write(12'hFFC, 2, 32'hC0);
    chk("wrap_mem_ffc", dmem[1023], 32'hC0);
    chk("wrap_mem_000", dmem[0], 32'hC1);
    do_read(12'hFFC, 2, 32'hC0);

    // zero-length command with iCmd_Valid held through DONE
    ab = acc_cnt;
    bb = bus_cnt;
    send_cmd(1'b1, 12'h100, 9'd0, 1'b1);
    @(negedge iClk);
    chk("len0_done", {31'd0, oDone}, 32'd1);
    chk("len0_busy", {31'd0, oBusy}, 32'd1);
    chk("len0_no_accept", {31'd0, oCmd_Ready}, 32'd0);
    tick();
    @(negedge iClk);
    chk("len0_rdy_again", {31'd0, oCmd_Ready}, 32'd1);
    chk("len0_done_once", {31'd0, oDone}, 32'd0);
    tick();
    iCmd_Valid = 1'b0;
    @(negedge iClk);
    chk("len0_second_done", {31'd0, oDone}, 32'd1);
    tick();
    @(negedge iClk);
    chk("len0_idle", {31'd0, oBusy}, 32'd0);
    tick();
    chk("len0_accepts", 32'(acc_cnt - ab), 32'd2);
    chk("len0_no_bus", 32'(bus_cnt - bb), 32'd0);

    // reset while the read FIFO is full
    iRd_Ready = 1'b0;
    send_cmd(1'b0, 12'h010, 9'd4, 1'b0);
    repeat (5) tick();
    @(negedge iClk);
    chk("rst_mid_full", {31'd0, oRd_Valid}, 32'd1);
    chk("rst_mid_stall", {31'd0, oBus_Valid}, 32'd0);
    tick();
    db = done_cnt;
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    @(negedge iClk);
    chk("rst_mid_rd_vld", {31'd0, oRd_Valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_mid_cmd_rdy", {31'd0, oCmd_Ready}, 32'd1);
    chk("rst_mid_done", {31'd0, oDone}, 32'd0);
    tick();
    do_write(12'h040, 1, 32'hD0);
    chk("rst_mid_done_cnt", 32'(done_cnt - db), 32'd1);
    chk("rst_mid_mem", dmem[16], 32'hD0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
